// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store stage.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        RESP = 2'b11
    } lsu_state_e;

    // Size 11 is never legal; halves need an even address, words a 4-byte aligned one.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic result;
        case (size)
            SZ_B:    result = 1'b0;
            SZ_H:    result = off[0];
            SZ_W:    result = (off != 2'b00);
            default: result = 1'b1;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/lsu_dmem_if.sv
// Single-outstanding request/grant/rvalid data-memory bus.
interface lsu_dmem_if #(
    parameter int XLEN = 32
) ();
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_align.sv
// Combinational lane placement for stores and extract/extend for loads.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      size,
    input  logic [1:0]      off,
    input  logic            zero_ext,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] load_word,
    output logic [3:0]      be,
    output logic [XLEN-1:0] lane_data,
    output logic [XLEN-1:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Byte enables and replicated store data for the addressed lanes.
    always_comb begin
        be        = 4'b0000;
        lane_data = store_data;
        case (size)
            SZ_B: begin
                be        = 4'b0001 << off;
                lane_data = {(XLEN/8){store_data[7:0]}};
            end
            SZ_H: begin
                be        = off[1] ? 4'b1100 : 4'b0011;
                lane_data = {(XLEN/16){store_data[15:0]}};
            end
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Pick the addressed byte/half out of the read word and extend it.
    always_comb begin
        byte_s = load_word[7:0];
        case (off)
            2'b00:   byte_s = load_word[7:0];
            2'b01:   byte_s = load_word[15:8];
            2'b10:   byte_s = load_word[23:16];
            2'b11:   byte_s = load_word[31:24];
            default: byte_s = load_word[7:0];
        endcase
        if (off[1]) begin
            half_s = load_word[31:16];
        end else begin
            half_s = load_word[15:0];
        end
        case (size)
            SZ_B:    load_data = zero_ext ? {{(XLEN-8){1'b0}}, byte_s}
                                          : {{(XLEN-8){byte_s[7]}}, byte_s};
            SZ_H:    load_data = zero_ext ? {{(XLEN-16){1'b0}}, half_s}
                                          : {{(XLEN-16){half_s[15]}}, half_s};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// Load/store stage: one outstanding data-memory access, load alignment and writeback handoff.
module lsu_stage
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic            we_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    input  logic [RD_W-1:0] rd_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            flush_i,
    lsu_dmem_if.master      dmem,
    output logic            done_o,
    output logic            wb_we_o,
    output logic [RD_W-1:0] wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            exc_o,
    output logic [XLEN-1:0] exc_addr_o
);

    lsu_state_e      state_r, state_nxt_s;
    logic            killed_r, killed_nxt_s;
    logic            req_r, req_nxt_s;
    logic            done_r, done_nxt_s;
    logic            wb_we_r, wb_we_nxt_s;
    logic            exc_r, exc_nxt_s;
    logic            load_ret_s;
    logic            we_r, uns_r;
    logic [1:0]      size_r, off_r;
    logic [RD_W-1:0] rd_r, wb_rd_r;
    logic [XLEN-1:0] addr_r, wdata_r, wb_data_r, exc_addr_r;
    logic [3:0]      be_r;
    logic            accept_s, mis_s;
    logic [1:0]      al_size_s, al_off_s;
    logic [3:0]      al_be_s;
    logic [XLEN-1:0] al_lane_s, al_load_s;

    // The retire cycle (RESP) already counts as idle so a new op can issue back-to-back.
    assign ready_o  = reset_ni && ((state_r == IDLE) || (state_r == RESP));
    assign accept_s = valid_i && ready_o && !flush_i;
    assign mis_s    = misaligned(size_i, addr_i[1:0]);

    // Align unit sees live operands at accept and captured ones while in flight.
    always_comb begin
        if ((state_r == REQ) || (state_r == WAIT)) begin
            al_size_s = size_r;
            al_off_s  = off_r;
        end else begin
            al_size_s = size_i;
            al_off_s  = addr_i[1:0];
        end
    end

    lsu_align #(.XLEN(XLEN)) u_align (
        .size       (al_size_s),
        .off        (al_off_s),
        .zero_ext   (uns_r),
        .store_data (wdata_i),
        .load_word  (dmem.rdata),
        .be         (al_be_s),
        .lane_data  (al_lane_s),
        .load_data  (al_load_s)
    );

    // Next state and the next values of the registered handshake pulses.
    always_comb begin
        state_nxt_s  = state_r;
        killed_nxt_s = killed_r;
        req_nxt_s    = 1'b0;
        done_nxt_s   = 1'b0;
        wb_we_nxt_s  = 1'b0;
        exc_nxt_s    = 1'b0;
        load_ret_s   = 1'b0;
        case (state_r)
            IDLE, RESP: begin
                if (accept_s && mis_s) begin
                    exc_nxt_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else if (accept_s) begin
                    state_nxt_s  = REQ;
                    req_nxt_s    = 1'b1;
                    killed_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (dmem.gnt) begin
                    // Grant beats a same-cycle flush: the access happens, only the retire is killed.
                    killed_nxt_s = flush_i;
                    if (!we_r) begin
                        state_nxt_s = WAIT;
                    end else if (flush_i) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = RESP;
                        done_nxt_s  = 1'b1;
                    end
                end else if (flush_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    req_nxt_s = 1'b1;
                end
            end
            WAIT: begin
                killed_nxt_s = killed_r | flush_i;
                if (dmem.rvalid && !(killed_r || flush_i)) begin
                    state_nxt_s = RESP;
                    done_nxt_s  = 1'b1;
                    wb_we_nxt_s = 1'b1;
                    load_ret_s  = 1'b1;
                end else if (dmem.rvalid) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, output registers and operands captured at accept.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r    <= IDLE;
            killed_r   <= 1'b0;
            req_r      <= 1'b0;
            done_r     <= 1'b0;
            wb_we_r    <= 1'b0;
            exc_r      <= 1'b0;
            we_r       <= 1'b0;
            uns_r      <= 1'b0;
            size_r     <= 2'b00;
            off_r      <= 2'b00;
            rd_r       <= '0;
            addr_r     <= '0;
            wdata_r    <= '0;
            be_r       <= 4'b0000;
            wb_rd_r    <= '0;
            wb_data_r  <= '0;
            exc_addr_r <= '0;
        end else begin
            state_r  <= state_nxt_s;
            killed_r <= killed_nxt_s;
            req_r    <= req_nxt_s;
            done_r   <= done_nxt_s;
            wb_we_r  <= wb_we_nxt_s;
            exc_r    <= exc_nxt_s;
            if (accept_s) begin
                we_r   <= we_i;
                uns_r  <= unsigned_i;
                size_r <= size_i;
                off_r  <= addr_i[1:0];
                rd_r   <= rd_i;
            end
            if (accept_s && mis_s) begin
                exc_addr_r <= addr_i;
            end
            if (accept_s && !mis_s) begin
                addr_r  <= {addr_i[XLEN-1:2], 2'b00};
                be_r    <= al_be_s;
                wdata_r <= al_lane_s;
            end
            if (load_ret_s) begin
                wb_rd_r   <= rd_r;
                wb_data_r <= al_load_s;
            end
        end
    end

    assign dmem.req   = req_r;
    assign dmem.we    = we_r;
    assign dmem.addr  = addr_r;
    assign dmem.be    = be_r;
    assign dmem.wdata = wdata_r;
    assign done_o     = done_r;
    assign wb_we_o    = wb_we_r;
    assign wb_rd_o    = wb_rd_r;
    assign wb_data_o  = wb_data_r;
    assign exc_o      = exc_r;
    assign exc_addr_o = exc_addr_r;

endmodule
